wb_port_arbiter: RTL and testbench



---
 rtl/wb_port_arbiter_pkg.sv | 30 +++
 rtl/wb_rr_pick.sv | 76 +++++++
 rtl/wb_port_arbiter.sv | 121 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and helpers for the write-back port arbiter.
// Core-wide width macros default here when include.vh has not already set them.
`ifndef LEN_PREG_ADDR
  `define LEN_PREG_ADDR 7
`endif
`ifndef LEN_WORD
  `define LEN_WORD 32
`endif
`ifndef WRITE_PARA
  `define WRITE_PARA 2
`endif
`ifndef WB_ARB_REQ
  `define WB_ARB_REQ 4
`endif

package wb_port_arbiter_pkg;

  typedef logic [`LEN_PREG_ADDR-1:0] preg_addr_t;
  typedef logic [`LEN_WORD-1:0]      word_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Rotating-priority picker: scans requesters from ptr, assigns nonzero, non-clashing
// addresses to write ports in scan order, and acks zero-address requests for free.
module wb_rr_pick #(
  parameter int N_REQ   = 4,
  parameter int W_DEPTH = 2,
  parameter int AW      = 7,
  localparam int PW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0]      valid,
  input  logic [AW*N_REQ-1:0]   addr,
  input  logic [PW-1:0]         ptr,
  output logic [N_REQ-1:0]      grant,
  output logic [N_REQ-1:0]      ready,
  output logic [W_DEPTH-1:0]    port_vld,
  output logic [PW*W_DEPTH-1:0] port_sel,
  output logic [PW-1:0]         ptr_next,
  output logic                  any_grant
);

  localparam int CW = PW + 1;

  logic [AW-1:0] addr_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_addr
    assign addr_arr[gi] = addr[gi*AW +: AW];
  end

  always_comb begin
    logic [PW-1:0] idx;
    logic [AW-1:0] cur;
    logic          clash;
    logic [CW-1:0] cnt;
    logic [AW-1:0] used_addr [W_DEPTH];

    grant     = '0;
    ready     = '0;
    port_vld  = '0;
    port_sel  = '0;
    ptr_next  = ptr;
    any_grant = 1'b0;
    idx       = '0;
    cur       = '0;
    clash     = 1'b0;
    cnt       = '0;
    for (int k = 0; k < W_DEPTH; k++) used_addr[k] = '0;

    for (int s = 0; s < N_REQ; s++) begin
      // N_REQ is a power of two, so wrapping the PW-bit sum is the modulo
      idx   = ptr + PW'(s);
      cur   = addr_arr[idx];
      clash = 1'b0;
      for (int k = 0; k < W_DEPTH; k++) begin
        if (CW'(k) < cnt && used_addr[k] == cur) clash = 1'b1;
      end
      if (valid[idx]) begin
        if (cur == '0) begin
          ready[idx] = 1'b1;
        end else if (!clash && cnt < CW'(W_DEPTH)) begin
          grant[idx] = 1'b1;
          ready[idx] = 1'b1;
          any_grant  = 1'b1;
          ptr_next   = idx + PW'(1);
          for (int k = 0; k < W_DEPTH; k++) begin
            if (CW'(k) == cnt) begin
              port_vld[k]            = 1'b1;
              port_sel[k*PW +: PW]   = idx;
              used_addr[k]           = cur;
            end
          end
          cnt = cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Write-back arbiter: shares the register-file write ports among result producers
// and registers the winners onto the regs write bus one cycle after acceptance.
`ifndef LEN_PREG_ADDR
  `define LEN_PREG_ADDR 7
`endif
`ifndef LEN_WORD
  `define LEN_WORD 32
`endif
`ifndef WRITE_PARA
  `define WRITE_PARA 2
`endif
`ifndef WB_ARB_REQ
  `define WB_ARB_REQ 4
`endif

module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int N_REQ   = `WB_ARB_REQ,
  parameter int W_DEPTH = `WRITE_PARA,
  localparam int AW     = `LEN_PREG_ADDR,
  localparam int DW     = `LEN_WORD,
  localparam int PW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [AW*N_REQ-1:0]   req_pa,
  input  logic [DW*N_REQ-1:0]   req_d,
  output logic [N_REQ-1:0]      req_ready,
  input  logic                  flush,
  output logic [W_DEPTH-1:0]    write_flag,
  output logic [AW*W_DEPTH-1:0] write_pa,
  output logic [DW*W_DEPTH-1:0] write_d,
  output logic [2:0]            busy_cnt
);

  logic [PW-1:0]         ptr_q, ptr_d;
  logic [W_DEPTH-1:0]    write_flag_q, write_flag_d;
  logic [AW*W_DEPTH-1:0] write_pa_q, write_pa_d;
  logic [DW*W_DEPTH-1:0] write_d_q, write_d_d;
  logic [2:0]            busy_cnt_q, busy_cnt_d;

  logic [N_REQ-1:0]      pick_grant, pick_ready;
  logic [W_DEPTH-1:0]    port_vld;
  logic [PW*W_DEPTH-1:0] port_sel;
  logic [PW-1:0]         ptr_next;
  logic                  any_grant;

  preg_addr_t    req_pa_arr  [N_REQ];
  word_t         req_d_arr   [N_REQ];
  logic [PW-1:0] port_sel_arr [W_DEPTH];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    assign req_pa_arr[gi] = req_pa[gi*AW +: AW];
    assign req_d_arr[gi]  = req_d[gi*DW +: DW];
  end

  for (genvar gi = 0; gi < W_DEPTH; gi++) begin : g_port
    assign port_sel_arr[gi] = port_sel[gi*PW +: PW];
  end

  wb_rr_pick #(
    .N_REQ   (N_REQ),
    .W_DEPTH (W_DEPTH),
    .AW      (AW)
  ) u_pick (
    .valid     (req_valid),
    .addr      (req_pa),
    .ptr       (ptr_q),
    .grant     (pick_grant),
    .ready     (pick_ready),
    .port_vld  (port_vld),
    .port_sel  (port_sel),
    .ptr_next  (ptr_next),
    .any_grant (any_grant)
  );

  assign req_ready = (rstn && !flush) ? pick_ready : '0;

  always_comb begin
    write_flag_d = '0;
    write_pa_d   = write_pa_q;
    write_d_d    = write_d_q;
    ptr_d        = ptr_q;
    if (!flush) begin
      write_flag_d = port_vld;
      if (any_grant) ptr_d = ptr_next;
      // Idle ports keep their last pa/d so the bus only toggles on real writes
      for (int k = 0; k < W_DEPTH; k++) begin
        if (port_vld[k]) begin
          write_pa_d[k*AW +: AW] = req_pa_arr[port_sel_arr[k]];
          write_d_d[k*DW +: DW]  = req_d_arr[port_sel_arr[k]];
        end
      end
    end
    busy_cnt_d = 3'(popcount8(8'(write_flag_d)));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q        <= '0;
      write_flag_q <= '0;
      write_pa_q   <= '0;
      write_d_q    <= '0;
      busy_cnt_q   <= '0;
    end else begin
      ptr_q        <= ptr_d;
      write_flag_q <= write_flag_d;
      write_pa_q   <= write_pa_d;
      write_d_q    <= write_d_d;
      busy_cnt_q   <= busy_cnt_d;
    end
  end

  assign write_flag = write_flag_q;
  assign write_pa   = write_pa_q;
  assign write_d    = write_d_q;
  assign busy_cnt   = busy_cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with 4 requesters and 2 write ports.
`ifndef LEN_PREG_ADDR
  `define LEN_PREG_ADDR 7
`endif
`ifndef LEN_WORD
  `define LEN_WORD 32
`endif
`ifndef WRITE_PARA
  `define WRITE_PARA 2
`endif
`ifndef WB_ARB_REQ
  `define WB_ARB_REQ 4
`endif

module tb_wb_port_arbiter;

  logic        clk;
  logic        rstn;
  logic [3:0]  req_valid;
  logic [27:0] req_pa;
  logic [127:0] req_d;
  logic [3:0]  req_ready;
  logic        flush;
  logic [1:0]  write_flag;
  logic [13:0] write_pa;
  logic [63:0] write_d;
  logic [2:0]  busy_cnt;

  logic [6:0]  pa [4];
  logic [31:0] dd [4];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int wait3 = 0;

  assign req_pa = {pa[3], pa[2], pa[1], pa[0]};
  assign req_d  = {dd[3], dd[2], dd[1], dd[0]};

  wb_port_arbiter #(
    .N_REQ   (4),
    .W_DEPTH (2)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_pa     (req_pa),
    .req_d      (req_d),
    .req_ready  (req_ready),
    .flush      (flush),
    .write_flag (write_flag),
    .write_pa   (write_pa),
    .write_d    (write_d),
    .busy_cnt   (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    $display("[TB] cycle %0d valid=%b flush=%b ready=%b", cyc, req_valid, flush, req_ready);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_pa_5678();
    pa[0] = 7'd5; pa[1] = 7'd6; pa[2] = 7'd7; pa[3] = 7'd8;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn  = 1'b0;
    flush = 1'b0;
    req_valid = 4'b1111;
    set_pa_5678();
    for (int i = 0; i < 4; i++) dd[i] = 32'h100 + 32'(i);

    // reset state
    #3;
    chk("rst_ready", 64'(req_ready), 64'(4'b0000));
    chk("rst_flag", 64'(write_flag), 64'(2'b00));
    chk("rst_pa", 64'(write_pa), 64'd0);
    chk("rst_busy", 64'(busy_cnt), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;

    // round robin, all four valid
    chk("rr0_ready", 64'(req_ready), 64'(4'b0011));
    tick();
    chk("rr1_flag", 64'(write_flag), 64'(2'b11));
    chk("rr1_pa", 64'(write_pa), 64'({7'd6, 7'd5}));
    chk("rr1_d", 64'(write_d), {32'h101, 32'h100});
    chk("rr1_busy", 64'(busy_cnt), 64'd2);
    chk("rr1_ready", 64'(req_ready), 64'(4'b1100));
    tick();
    chk("rr2_pa", 64'(write_pa), 64'({7'd8, 7'd7}));
    chk("rr2_d", 64'(write_d), {32'h103, 32'h102});
    chk("rr2_ready", 64'(req_ready), 64'(4'b0011));
    tick();
    chk("rr3_pa", 64'(write_pa), 64'({7'd6, 7'd5}));
    chk("rr3_ready", 64'(req_ready), 64'(4'b1100));
    tick();
    chk("rr4_pa", 64'(write_pa), 64'({7'd8, 7'd7}));
    chk("rr4_busy", 64'(busy_cnt), 64'd2);
    req_valid = 4'b0000;
    tick();
    chk("idle_flag", 64'(write_flag), 64'(2'b00));
    chk("idle_busy", 64'(busy_cnt), 64'd0);
    chk("idle_pa_hold", 64'(write_pa), 64'({7'd8, 7'd7}));

    // zero-address request is acked but takes no port
    req_valid = 4'b0111;
    pa[0] = 7'd0; pa[1] = 7'd3; pa[2] = 7'd4;
    #1;
    chk("zero_ready", 64'(req_ready), 64'(4'b0111));
    tick();
    chk("zero_flag", 64'(write_flag), 64'(2'b11));
    chk("zero_pa", 64'(write_pa), 64'({7'd4, 7'd3}));
    chk("zero_busy", 64'(busy_cnt), 64'd2);
    set_pa_5678();
    req_valid = 4'b1111;
    #1;
    chk("zero_ptr3_ready", 64'(req_ready), 64'(4'b1001));
    req_valid = 4'b0000;
    tick();
    chk("zero_idle_flag", 64'(write_flag), 64'(2'b00));

    // same-address conflict: scan from ptr=3 reaches req0 before req1
    req_valid = 4'b0011;
    pa[0] = 7'd9; pa[1] = 7'd9;
    dd[0] = 32'hA; dd[1] = 32'hB;
    #1;
    chk("conf1_ready", 64'(req_ready), 64'(4'b0001));
    tick();
    chk("conf1_flag", 64'(write_flag), 64'(2'b01));
    chk("conf1_pa", 64'(write_pa), 64'({7'd4, 7'd9}));
    chk("conf1_d0", 64'(write_d[31:0]), 64'h0A);
    req_valid = 4'b0010;
    #1;
    chk("conf2_ready", 64'(req_ready), 64'(4'b0010));
    tick();
    chk("conf2_flag", 64'(write_flag), 64'(2'b01));
    chk("conf2_pa0", 64'(write_pa[6:0]), 64'd9);
    chk("conf2_d0", 64'(write_d[31:0]), 64'h0B);
    req_valid = 4'b0000;
    tick();

    // flush: ptr=2 on entry
    set_pa_5678();
    for (int i = 0; i < 4; i++) dd[i] = 32'h200 + 32'(i);
    req_valid = 4'b1111;
    #1;
    chk("pre_flush_ready", 64'(req_ready), 64'(4'b1100));
    tick();
    chk("pre_flush_pa", 64'(write_pa), 64'({7'd8, 7'd7}));
    flush = 1'b1;
    #1;
    chk("flush_ready", 64'(req_ready), 64'(4'b0000));
    chk("flush_bus_flag", 64'(write_flag), 64'(2'b11));
    chk("flush_bus_pa", 64'(write_pa), 64'({7'd8, 7'd7}));
    tick();
    chk("post_flush_flag", 64'(write_flag), 64'(2'b00));
    chk("post_flush_busy", 64'(busy_cnt), 64'd0);
    chk("post_flush_pa", 64'(write_pa), 64'({7'd8, 7'd7}));
    flush = 1'b0;
    #1;
    chk("post_flush_ptr", 64'(req_ready), 64'(4'b0011));

    // req3 held valid while req0..2 toggle
    wait3 = 0;
    for (int t = 0; t < 8; t++) begin
      logic [3:0] exp_rdy;
      req_valid = (t % 2 == 0) ? 4'b1111 : 4'b1000;
      exp_rdy   = (t % 2 == 0) ? 4'b0011 : 4'b1000;
      #1;
      chk("starve_ready", 64'(req_ready), 64'(exp_rdy));
      if (req_ready[3]) wait3 = 0;
      else wait3++;
      chk("starve_wait", 64'(wait3 < 2), 64'd1);
      tick();
    end

    // asynchronous reset in the middle of a cycle
    req_valid = 4'b0001;
    pa[0] = 7'd5;
    tick();
    chk("mid_pre_flag", 64'(write_flag), 64'(2'b01));
    req_valid = 4'b1111;
    set_pa_5678();
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_flag", 64'(write_flag), 64'(2'b00));
    chk("mid_rst_pa", 64'(write_pa), 64'd0);
    chk("mid_rst_d", 64'(write_d), 64'd0);
    chk("mid_rst_busy", 64'(busy_cnt), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'(4'b0000));
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("mid_rel_ptr0", 64'(req_ready), 64'(4'b0011));
    tick();
    chk("mid_rel_pa", 64'(write_pa), 64'({7'd6, 7'd5}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
